instr_mem_ctrl: RTL

Parametrised, writable instruction memory on the shared system bus. It decodes its own chip-select nibble from the 16-bit address and, on a read, returns a full bus-wide line of LANES consecutive instructions. It accepts program-load writes when not write-protected and reports out-of-range accesses. It sits beside the other bus peers and is fetched by the processor's instruction fetch unit.

---
 rtl/instr_mem_pkg.sv | 41 ++++
 rtl/instr_mem_ctrl_if.sv | 28 ++
 rtl/instr_mem_array.sv | 48 ++++
 rtl/instr_mem_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// ============================================================================
// Module : instr_mem_pkg
// Brief  : Shared constants, state encoding and boot image for the instruction memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_mem_pkg;

    localparam logic [3:0] INSTR_MEM_SEL = 4'h1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRIVE = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int INIT_LEN = 16;

    localparam logic [31:0] INIT_PROG [INIT_LEN] = '{
        32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003,
        32'hA000_0004, 32'hA000_0005, 32'hA000_0006, 32'hA000_0007,
        32'hA000_0008, 32'hA000_0009, 32'hA000_000A, 32'hA000_000B,
        32'hA000_000C, 32'hA000_000D, 32'hA000_000E, 32'hA000_000F
    };

    function automatic int lanes(input int busW, input int instrW);
        return busW / instrW;
    endfunction

    // Boot word k; locations past the image read as zero.
    function automatic logic [31:0] initWord(input int k);
        if (k < INIT_LEN)
            return INIT_PROG[k & (INIT_LEN - 1)];
        return 32'h0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_mem_ctrl_if.sv
// ============================================================================
// Module : instr_mem_ctrl_if
// Brief  : Address/handshake/status bundle between a bus master and the instruction memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_mem_ctrl_if;
    logic [15:0] address;
    logic        nRead;
    logic        nWrite;
    logic        WriteProtect;
    logic        Ready;
    logic        AddrErr;
    logic [15:0] FetchCount;

    modport master (
        output address, nRead, nWrite, WriteProtect,
        input  Ready, AddrErr, FetchCount
    );

    modport slave (
        input  address, nRead, nWrite, WriteProtect,
        output Ready, AddrErr, FetchCount
    );
endinterface

`default_nettype wire

// File: rtl/instr_mem_array.sv
// ============================================================================
// Module : instr_mem_array
// Brief  : DEPTH x INSTR_W storage, one write port, zero-filled line-wide read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int BUS_W   = 256,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4
) (
    input  wire logic               Clk,
    input  wire logic               nReset,
    input  wire logic               i_wrEn,
    input  wire logic [ADDR_W-1:0]  i_wrIdx,
    input  wire logic [INSTR_W-1:0] i_wrData,
    input  wire logic [11:0]        i_rdBase,
    output logic      [BUS_W-1:0]   o_rdLine
);

    localparam int c_LANES = lanes(BUS_W, INSTR_W);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= INSTR_W'(initWord(k));
        end else if (i_wrEn) begin
            r_mem[i_wrIdx] <= i_wrData;
        end
    end

    // Lanes running past the end of the array read as zero rather than wrapping.
    for (genvar i = 0; i < c_LANES; i++) begin : g_lane
        logic [12:0] w_idx;
        assign w_idx = {1'b0, i_rdBase} + 13'(i);
        assign o_rdLine[i*INSTR_W +: INSTR_W] =
            (w_idx < 13'(DEPTH)) ? r_mem[w_idx[ADDR_W-1:0]] : '0;
    end

endmodule

`default_nettype wire

// File: rtl/instr_mem_ctrl.sv
// ============================================================================
// Module : instr_mem_ctrl
// Brief  : Bus-mapped instruction memory: line fetch, program load, error flag, fetch counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int         BUS_W   = 256,
    parameter int         INSTR_W = 32,
    parameter int         DEPTH   = 16,
    parameter logic [3:0] MEM_SEL = INSTR_MEM_SEL
) (
    input  wire logic             Clk,
    input  wire logic             nReset,
    inout  wire       [BUS_W-1:0] DataBus,
    instr_mem_ctrl_if.slave       bus
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             r_state;
    logic [11:0]        r_base;
    logic [BUS_W-1:0]   r_line;
    logic               r_ready;
    logic               r_drive;
    logic               r_addrErr;
    logic [15:0]        r_fetchCount;

    logic               w_sel;
    logic [11:0]        w_idx;
    logic               w_idxOk;
    logic               w_baseOk;
    logic               w_wrEn;
    logic [BUS_W-1:0]   w_rdLine;

    assign w_sel    = (bus.address[15:12] == MEM_SEL);
    assign w_idx    = bus.address[11:0];
    assign w_idxOk  = ({4'd0, w_idx}  < 16'(DEPTH));
    assign w_baseOk = ({4'd0, r_base} < 16'(DEPTH));
    assign w_wrEn   = (r_state == WRITE) && !bus.WriteProtect && w_idxOk;

    instr_mem_array #(
        .BUS_W   (BUS_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (c_ADDR_W)
    ) u_array (
        .Clk      (Clk),
        .nReset   (nReset),
        .i_wrEn   (w_wrEn),
        .i_wrIdx  (w_idx[c_ADDR_W-1:0]),
        .i_wrData (DataBus[INSTR_W-1:0]),
        .i_rdBase (r_base),
        .o_rdLine (w_rdLine)
    );

    always_ff @(negedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_line       <= '0;
            r_ready      <= 1'b0;
            r_drive      <= 1'b0;
            r_addrErr    <= 1'b0;
            r_fetchCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    r_drive <= 1'b0;
                    if (w_sel && !bus.nRead) begin
                        r_base  <= w_idx;
                        r_state <= FETCH;
                    end else if (w_sel && !bus.nWrite) begin
                        r_state <= WRITE;
                    end
                end
                FETCH: begin
                    r_line    <= w_rdLine;
                    r_addrErr <= !w_baseOk;
                    if (r_fetchCount != 16'hFFFF)
                        r_fetchCount <= r_fetchCount + 16'd1;
                    r_state   <= DRIVE;
                end
                DRIVE: begin
                    if (bus.nRead) begin
                        r_ready <= 1'b0;
                        r_drive <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_ready <= 1'b1;
                        r_drive <= 1'b1;
                    end
                end
                WRITE: begin
                    // A protected write is silently dropped: no pulse, flag untouched.
                    if (!bus.WriteProtect) begin
                        r_ready   <= 1'b1;
                        r_addrErr <= !w_idxOk;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign DataBus        = (r_drive && !bus.nRead) ? r_line : 'z;
    assign bus.Ready      = r_ready;
    assign bus.AddrErr    = r_addrErr;
    assign bus.FetchCount = r_fetchCount;

endmodule

`default_nettype wire
